// File: rtl/link_mm_host_bridge_if.sv
// Host register bus plus registered MM request/response signals of the link bridge.
// The slave modport is the bridge's view; master is the host/decoder environment.
interface link_mm_host_bridge_if;
  logic [16:0] iHOST_ADDR;
  logic        iHOST_WR;
  logic        iHOST_RD;
  logic [63:0] iHOST_WR_DATA;
  logic        oHOST_WAIT;
  logic [63:0] oHOST_RD_DATA;
  logic        oHOST_RD_DATA_V;
  logic [16:0] oMM_ADDR;
  logic [63:0] oMM_WR_DATA;
  logic        oMM_WR_EN;
  logic        oMM_RD_EN;
  logic [63:0] iMM_RD_DATA;
  logic        iMM_RD_DATA_V;

  modport slave (
    input  iHOST_ADDR, iHOST_WR, iHOST_RD, iHOST_WR_DATA, iMM_RD_DATA, iMM_RD_DATA_V,
    output oHOST_WAIT, oHOST_RD_DATA, oHOST_RD_DATA_V, oMM_ADDR, oMM_WR_DATA,
           oMM_WR_EN, oMM_RD_EN
  );

  modport master (
    output iHOST_ADDR, iHOST_WR, iHOST_RD, iHOST_WR_DATA, iMM_RD_DATA, iMM_RD_DATA_V,
    input  oHOST_WAIT, oHOST_RD_DATA, oHOST_RD_DATA_V, oMM_ADDR, oMM_WR_DATA,
           oMM_WR_EN, oMM_RD_EN
  );
endinterface

// File: rtl/link_mm_host_bridge.sv
// Host-side request sequencer for the link register map: one read outstanding at most.
// Define LINK_MM_RD_TIMEOUT_EN to build the read timeout (TIMEOUT_CYCLES, TMO_SIG).
module link_mm_host_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] TMO_SIG        = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  link_mm_host_bridge_if.slave bus,
  output logic                 oPROTO_ERR,
  output logic [7:0]           oSTRAY_CNT,
  output logic [15:0]          oTMO_CNT
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0] state;

  assign bus.oHOST_WAIT = (state == RD_WAIT);

`ifdef LINK_MM_RD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;
  logic        tmo_fire;

  // Real data on the final edge beats the timeout.
  assign tmo_fire = (state == RD_WAIT) && !bus.iMM_RD_DATA_V && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      oTMO_CNT <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_fire) begin
      if (oTMO_CNT != 16'hFFFF) oTMO_CNT <= oTMO_CNT + 16'd1;
    end else if (!bus.iMM_RD_DATA_V) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_cfg;

  assign oTMO_CNT   = '0;
  assign unused_cfg = ^{TIMEOUT_CYCLES[15:0], TMO_SIG};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      bus.oMM_WR_EN       <= 1'b0;
      bus.oMM_RD_EN       <= 1'b0;
      bus.oMM_ADDR        <= '0;
      bus.oMM_WR_DATA     <= '0;
      bus.oHOST_RD_DATA   <= '0;
      bus.oHOST_RD_DATA_V <= 1'b0;
      oPROTO_ERR          <= 1'b0;
      oSTRAY_CNT          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus.oMM_WR_EN       <= 1'b0;
      bus.oMM_RD_EN       <= 1'b0;
      bus.oHOST_RD_DATA_V <= 1'b0;

      if (state == IDLE) begin
        if (bus.iMM_RD_DATA_V && oSTRAY_CNT != 8'hFF) oSTRAY_CNT <= oSTRAY_CNT + 8'd1;

        if (bus.iHOST_WR) begin
          bus.oMM_WR_EN   <= 1'b1;
          bus.oMM_ADDR    <= bus.iHOST_ADDR;
          bus.oMM_WR_DATA <= bus.iHOST_WR_DATA;
          if (bus.iHOST_RD) oPROTO_ERR <= 1'b1;
        end else if (bus.iHOST_RD) begin
          bus.oMM_RD_EN <= 1'b1;
          bus.oMM_ADDR  <= bus.iHOST_ADDR;
          state         <= RD_WAIT;
        end
      end else begin
        if (bus.iMM_RD_DATA_V) begin
          bus.oHOST_RD_DATA   <= bus.iMM_RD_DATA;
          bus.oHOST_RD_DATA_V <= 1'b1;
          state               <= IDLE;
        end
`ifdef LINK_MM_RD_TIMEOUT_EN
        // oMM_ADDR cannot change while waiting, so it doubles as the latched read address.
        else if (tmo_fire) begin
          bus.oHOST_RD_DATA   <= {TMO_SIG, 15'b0, bus.oMM_ADDR};
          bus.oHOST_RD_DATA_V <= 1'b1;
          state               <= IDLE;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_link_mm_host_bridge.sv
// Self-checking bench for link_mm_host_bridge: directed vector table, hand-written
// multi-cycle sequences and random traffic against a transaction-level model.
module tb_link_mm_host_bridge;

  localparam int unsigned TMO = 16;
`ifdef LINK_MM_RD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        proto_err;
  logic [7:0]  stray_cnt;
  logic [15:0] tmo_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  link_mm_host_bridge_if bus ();

  link_mm_host_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .TMO_SIG       (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .oPROTO_ERR(proto_err),
    .oSTRAY_CNT(stray_cnt),
    .oTMO_CNT  (tmo_cnt)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [16:0] addr;
    logic [63:0] wdata;
    logic        mmv;
    logic [63:0] mmdata;
    logic        e_wait;
    logic        e_wr_en;
    logic        e_rd_en;
    logic        e_rdv;
    logic [16:0] e_addr;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
    logic        e_proto;
    logic [7:0]  e_stray;
  } vec_t;

  vec_t vt[$];

  // Transaction-level model: a read is either outstanding or not, and counts its waited cycles.
  bit          m_busy;
  int          m_waited;
  logic [16:0] m_raddr;
  logic        e_wr_en, e_rd_en, e_rdv, e_proto;
  logic [16:0] e_addr;
  logic [63:0] e_wdata, e_rdata;
  logic [7:0]  e_stray;
  logic [15:0] e_tmo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_waited = 0; m_raddr = '0;
    e_wr_en = 1'b0; e_rd_en = 1'b0; e_rdv = 1'b0; e_proto = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_stray = '0; e_tmo = '0;
  endtask

  task automatic model_edge(input logic wr, input logic rd, input logic [16:0] addr,
                            input logic [63:0] wdata, input logic mmv, input logic [63:0] mmdata);
    e_wr_en = 1'b0; e_rd_en = 1'b0; e_rdv = 1'b0;
    if (!m_busy) begin
      if (mmv && e_stray != 8'hFF) e_stray = e_stray + 8'd1;
      if (wr) begin
        e_wr_en = 1'b1; e_addr = addr; e_wdata = wdata;
        if (rd) e_proto = 1'b1;
      end else if (rd) begin
        e_rd_en = 1'b1; e_addr = addr; m_raddr = addr; m_busy = 1'b1; m_waited = 0;
      end
    end else if (mmv) begin
      e_rdv = 1'b1; e_rdata = mmdata; m_busy = 1'b0;
    end else begin
      m_waited++;
      if (TMO_EN && m_waited == int'(TMO)) begin
        e_rdv = 1'b1; e_rdata = {32'hDEAD_BEEF, 15'b0, m_raddr}; m_busy = 1'b0;
        if (e_tmo != 16'hFFFF) e_tmo = e_tmo + 16'd1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".wait"},   64'(bus.oHOST_WAIT),      64'(m_busy));
    check({tag, ".wr_en"},  64'(bus.oMM_WR_EN),       64'(e_wr_en));
    check({tag, ".rd_en"},  64'(bus.oMM_RD_EN),       64'(e_rd_en));
    check({tag, ".rdv"},    64'(bus.oHOST_RD_DATA_V), 64'(e_rdv));
    check({tag, ".addr"},   64'(bus.oMM_ADDR),        64'(e_addr));
    check({tag, ".wdata"},  bus.oMM_WR_DATA,          e_wdata);
    check({tag, ".rdata"},  bus.oHOST_RD_DATA,        e_rdata);
    check({tag, ".proto"},  64'(proto_err),           64'(e_proto));
    check({tag, ".stray"},  64'(stray_cnt),           64'(e_stray));
    check({tag, ".tmo"},    64'(tmo_cnt),             64'(e_tmo));
  endtask

  // NOTE: inputs are driven with blocking assignments 1 time unit after the edge.
  task automatic cycle(input string tag, input logic wr, input logic rd, input logic [16:0] addr,
                       input logic [63:0] wdata, input logic mmv, input logic [63:0] mmdata);
    bus.iHOST_WR = wr; bus.iHOST_RD = rd; bus.iHOST_ADDR = addr;
    bus.iHOST_WR_DATA = wdata; bus.iMM_RD_DATA_V = mmv; bus.iMM_RD_DATA = mmdata;
    @(posedge clk);
    model_edge(wr, rd, addr, wdata, mmv, mmdata);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 17'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    bus.iHOST_WR = 1'b0; bus.iHOST_RD = 1'b0; bus.iHOST_ADDR = '0;
    bus.iHOST_WR_DATA = '0; bus.iMM_RD_DATA_V = 1'b0; bus.iMM_RD_DATA = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Test-plan vectors; expectations are the outputs after the edge that samples each row.
    vt.push_back(vec_t'{1'b1, 1'b0, 17'h00010, 64'h1, 1'b0, 64'h0,
                        1'b0, 1'b1, 1'b0, 1'b0, 17'h00010, 64'h1, 64'h0, 1'b0, 8'd0});
    vt.push_back(vec_t'{1'b1, 1'b0, 17'h04000, 64'h2, 1'b0, 64'h0,
                        1'b0, 1'b1, 1'b0, 1'b0, 17'h04000, 64'h2, 64'h0, 1'b0, 8'd0});
    vt.push_back(vec_t'{1'b1, 1'b0, 17'h08000, 64'h3, 1'b0, 64'h0,
                        1'b0, 1'b1, 1'b0, 1'b0, 17'h08000, 64'h3, 64'h0, 1'b0, 8'd0});
    vt.push_back(vec_t'{1'b0, 1'b1, 17'h04020, 64'h0, 1'b0, 64'h0,
                        1'b1, 1'b0, 1'b1, 1'b0, 17'h04020, 64'h3, 64'h0, 1'b0, 8'd0});
    for (int i = 0; i < 3; i++)
      vt.push_back(vec_t'{1'b0, 1'b0, 17'h0, 64'h0, 1'b0, 64'h0,
                          1'b1, 1'b0, 1'b0, 1'b0, 17'h04020, 64'h3, 64'h0, 1'b0, 8'd0});
    vt.push_back(vec_t'{1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'hCAFE_0000_1234_5678,
                        1'b0, 1'b0, 1'b0, 1'b1, 17'h04020, 64'h3, 64'hCAFE_0000_1234_5678, 1'b0, 8'd0});
    vt.push_back(vec_t'{1'b1, 1'b1, 17'h00008, 64'h55, 1'b0, 64'h0,
                        1'b0, 1'b1, 1'b0, 1'b0, 17'h00008, 64'h55, 64'hCAFE_0000_1234_5678, 1'b1, 8'd0});
    vt.push_back(vec_t'{1'b0, 1'b0, 17'h0, 64'h0, 1'b0, 64'h0,
                        1'b0, 1'b0, 1'b0, 1'b0, 17'h00008, 64'h55, 64'hCAFE_0000_1234_5678, 1'b1, 8'd0});
    vt.push_back(vec_t'{1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h99,
                        1'b0, 1'b0, 1'b0, 1'b0, 17'h00008, 64'h55, 64'hCAFE_0000_1234_5678, 1'b1, 8'd1});

    do_reset();

    foreach (vt[i]) begin
      cycle($sformatf("vec%0d", i), vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata,
            vt[i].mmv, vt[i].mmdata);
      check($sformatf("vec%0d.t_wait", i),  64'(bus.oHOST_WAIT),      64'(vt[i].e_wait));
      check($sformatf("vec%0d.t_wr_en", i), 64'(bus.oMM_WR_EN),       64'(vt[i].e_wr_en));
      check($sformatf("vec%0d.t_rd_en", i), 64'(bus.oMM_RD_EN),       64'(vt[i].e_rd_en));
      check($sformatf("vec%0d.t_rdv", i),   64'(bus.oHOST_RD_DATA_V), 64'(vt[i].e_rdv));
      check($sformatf("vec%0d.t_addr", i),  64'(bus.oMM_ADDR),        64'(vt[i].e_addr));
      check($sformatf("vec%0d.t_wdata", i), bus.oMM_WR_DATA,          vt[i].e_wdata);
      check($sformatf("vec%0d.t_proto", i), 64'(proto_err),           64'(vt[i].e_proto));
      check($sformatf("vec%0d.t_stray", i), 64'(stray_cnt),           64'(vt[i].e_stray));
    end
    check("proto_sticky", 64'(proto_err), 64'h1);

    do_reset();
`ifdef LINK_MM_RD_TIMEOUT_EN
    // Unanswered read: 16 wait cycles, then the signature response.
    cycle("tmo_rd", 1'b0, 1'b1, 17'h1ABCD, 64'h0, 1'b0, 64'h0);
    for (int i = 0; i < 15; i++) begin
      idle("tmo_wait");
      check("tmo_wait_hi", 64'(bus.oHOST_WAIT), 64'h1);
    end
    idle("tmo_fire");
    check("tmo_rdv",   64'(bus.oHOST_RD_DATA_V), 64'h1);
    check("tmo_rdata", bus.oHOST_RD_DATA,        64'hDEAD_BEEF_0001_ABCD);
    check("tmo_cnt",   64'(tmo_cnt),             64'h1);
    cycle("tmo_late", 1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h1234);
    check("tmo_stray", 64'(stray_cnt), 64'h1);

    // Data on the same edge the timeout would fire.
    cycle("tie_rd", 1'b0, 1'b1, 17'h00777, 64'h0, 1'b0, 64'h0);
    for (int i = 0; i < 15; i++) idle("tie_wait");
    cycle("tie_data", 1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF);
    check("tie_rdata", bus.oHOST_RD_DATA, 64'h0123_4567_89AB_CDEF);
    check("tie_tmo",   64'(tmo_cnt),      64'h1);
`else
    // Without the timeout the read waits indefinitely for data.
    cycle("nt_rd", 1'b0, 1'b1, 17'h1ABCD, 64'h0, 1'b0, 64'h0);
    for (int i = 0; i < 40; i++) idle("nt_wait");
    check("nt_wait_hi", 64'(bus.oHOST_WAIT), 64'h1);
    cycle("nt_data", 1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h0BAD_F00D);
    check("nt_rdata", bus.oHOST_RD_DATA, 64'h0BAD_F00D);
    check("nt_tmo",   64'(tmo_cnt),      64'h0);
`endif

    // Reset asserted mid-read, then a normal write and a late stray return.
    cycle("mr_rd", 1'b0, 1'b1, 17'h00123, 64'h0, 1'b0, 64'h0);
    idle("mr_wait");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("mr_rst");
    check("mr_rst_wait", 64'(bus.oHOST_WAIT), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle("mr_wr", 1'b1, 1'b0, 17'h00044, 64'hA5A5, 1'b0, 64'h0);
    check("mr_wr_en", 64'(bus.oMM_WR_EN), 64'h1);
    cycle("mr_late", 1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h77);
    check("mr_stray", 64'(stray_cnt), 64'h1);

    // Random traffic including illegal WR+RD and stray returns.
    for (int n = 0; n < 600; n++) begin
      int   r;
      logic w, rd, v;
      r  = int'($urandom_range(0, 15));
      w  = (r < 5);
      rd = (r >= 4 && r < 9);
      v  = ($urandom_range(0, 7) == 0);
      cycle("rnd", w, rd, 17'($urandom), {$urandom, $urandom}, v, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
